phys_reg_freelist: RTL and testbench

- Circular free list of physical register numbers for a 3-wide out-of-order core.
- Supplies up to three free physical registers per cycle to dispatch/rename.
- Accepts up to three freed registers per cycle from retire.
- Rewinds its head pointer on branch-misprediction recovery to a checkpoint the ROB captured from the Head output at dispatch.

---
 rtl/phys_reg_freelist.sv | 111 +++++++++++
 tb/tb_phys_reg_freelist.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register numbers for a 3-wide rename stage.
// Hands out up to three free registers per cycle, accepts up to three retired
// registers per cycle, and rewinds its head to a checkpoint on branch recovery.
module phys_reg_freelist #(
    parameter int unsigned PR  = 6,
    parameter int unsigned ROB = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          DispatchEN,
    input  logic [2:0]          RetireEN,
    input  logic [2:0][PR-1:0]  RetireReg,
    input  logic                BPRecoverEN,
    input  logic [ROB-1:0]      BPRecoverHead,
    output logic [2:0][PR-1:0]  FreeReg,
    output logic [PR-1:0]       Head,
    output logic [2:0]          FreeRegValid,
    output logic [4:0]          fl_distance,
    output logic [31:0][PR-1:0] array_display,
    output logic [4:0]          head_display,
    output logic [4:0]          tail_display,
    output logic                empty_display
);

    localparam int unsigned FL_SIZE = 32;
    localparam int unsigned PTR_W   = 5;
    localparam int unsigned CNT_W   = 6;

    logic [PR-1:0]    fl_array [FL_SIZE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] free_count;

    logic [2:0]       dispatch_grant;
    logic [1:0]       alloc_count;
    logic [1:0]       retire_count;
    logic [1:0]       retire_ofs [3];
    logic [PTR_W-1:0] recover_head;
    logic [PTR_W-1:0] rewind_gap;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] free_count_next;

    // Read ports: the next three candidates and status derived from the count
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            FreeReg[i]      = fl_array[head + PTR_W'(i)];
            FreeRegValid[i] = free_count > CNT_W'(i);
        end
        for (int i = 0; i < 32; i++) begin
            array_display[i] = fl_array[i];
        end
        Head          = PR'(head);
        head_display  = head;
        tail_display  = tail;
        fl_distance   = head - tail;
        empty_display = (free_count == '0);
    end

    // Next-state: allocation, compacted retire slots and recovery rewind
    always_comb begin
        dispatch_grant  = DispatchEN & FreeRegValid;
        alloc_count     = 2'(dispatch_grant[0]) + 2'(dispatch_grant[1]) + 2'(dispatch_grant[2]);
        retire_count    = 2'(RetireEN[0]) + 2'(RetireEN[1]) + 2'(RetireEN[2]);
        retire_ofs[0]   = 2'd0;
        retire_ofs[1]   = 2'(RetireEN[0]);
        retire_ofs[2]   = 2'(RetireEN[0]) + 2'(RetireEN[1]);
        tail_next       = tail + PTR_W'(retire_count);
        recover_head    = BPRecoverHead[PTR_W-1:0];
        rewind_gap      = tail_next - recover_head;
        head_next       = head + PTR_W'(alloc_count);
        free_count_next = free_count - CNT_W'(alloc_count) + CNT_W'(retire_count);
        if (BPRecoverEN) begin
            head_next = recover_head;
            if (recover_head == head) begin
                free_count_next = free_count + CNT_W'(retire_count);
            end else if (rewind_gap == '0) begin
                // Gap of zero with a moved head means the whole ring is free
                free_count_next = CNT_W'(FL_SIZE);
            end else begin
                free_count_next = CNT_W'(rewind_gap);
            end
        end
    end

    // State register: list storage, pointers and free count
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                fl_array[i] <= PR'(FL_SIZE + 32'(i));
            end
            head       <= '0;
            tail       <= '0;
            free_count <= CNT_W'(FL_SIZE);
        end else begin
            for (int w = 0; w < 3; w++) begin
                if (RetireEN[w]) begin
                    fl_array[tail + PTR_W'(retire_ofs[w])] <= RetireReg[w];
                end
            end
            head       <= head_next;
            tail       <= tail_next;
            free_count <= free_count_next;
        end
    end

    // Retiring into a full list would overwrite live entries
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (7'(free_count) + 7'(retire_count)) <= 7'd32);

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Self-checking bench for phys_reg_freelist: directed plan scenarios plus
// randomized dispatch/retire/recovery traffic against a ring-buffer model.
module tb_phys_reg_freelist;

    localparam int unsigned PR  = 6;
    localparam int unsigned ROB = 5;

    logic                clock = 1'b0;
    logic                reset;
    logic [2:0]          DispatchEN;
    logic [2:0]          RetireEN;
    logic [2:0][PR-1:0]  RetireReg;
    logic                BPRecoverEN;
    logic [ROB-1:0]      BPRecoverHead;
    logic [2:0][PR-1:0]  FreeReg;
    logic [PR-1:0]       Head;
    logic [2:0]          FreeRegValid;
    logic [4:0]          fl_distance;
    logic [31:0][PR-1:0] array_display;
    logic [4:0]          head_display;
    logic [4:0]          tail_display;
    logic                empty_display;

    phys_reg_freelist #(.PR(PR), .ROB(ROB)) dut (
        .clock         (clock),
        .reset         (reset),
        .DispatchEN    (DispatchEN),
        .RetireEN      (RetireEN),
        .RetireReg     (RetireReg),
        .BPRecoverEN   (BPRecoverEN),
        .BPRecoverHead (BPRecoverHead),
        .FreeReg       (FreeReg),
        .Head          (Head),
        .FreeRegValid  (FreeRegValid),
        .fl_distance   (fl_distance),
        .array_display (array_display),
        .head_display  (head_display),
        .tail_display  (tail_display),
        .empty_display (empty_display)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: ring contents, plain-integer pointers and free count
    int m_mem [32];
    int m_head;
    int m_tail;
    int m_free;

    function automatic int mod32(input int v);
        return ((v % 32) + 32) % 32;
    endfunction

    function automatic logic [2:0] m_valid();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = (m_free > i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
        m_head = 0;
        m_tail = 0;
        m_free = 32;
    endtask

    task automatic idle_inputs();
        DispatchEN    = 3'b000;
        RetireEN      = 3'b000;
        RetireReg     = '0;
        BPRecoverEN   = 1'b0;
        BPRecoverHead = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of traffic and advance the model by the same rules
    task automatic cycle(input logic [2:0] d, input logic [2:0] r,
                         input int r0, input int r1, input int r2,
                         input logic rec, input int rh);
        int regs [3];
        int want;
        int alloc;
        int k;
        regs[0] = r0; regs[1] = r1; regs[2] = r2;
        DispatchEN    = d;
        RetireEN      = r;
        RetireReg[0]  = PR'(r0);
        RetireReg[1]  = PR'(r1);
        RetireReg[2]  = PR'(r2);
        BPRecoverEN   = rec;
        BPRecoverHead = ROB'(rh);
        want  = int'(d[0]) + int'(d[1]) + int'(d[2]);
        alloc = (want < m_free) ? want : m_free;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            if (r[i]) begin
                m_mem[mod32(m_tail + k)] = regs[i];
                k++;
            end
        end
        if (rec) begin
            // Rewinding by g entries returns those g entries to the free pool
            m_free = m_free + k + mod32(m_head - rh);
            m_head = rh;
        end else begin
            m_free = m_free - alloc + k;
            m_head = mod32(m_head + alloc);
        end
        m_tail = mod32(m_tail + k);
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (FreeReg[i] !== PR'(32 + i)) begin
                errors++;
                $display("FAIL reset_freereg%0d got %0d exp %0d", i, FreeReg[i], 32 + i);
            end
        end
        checks++;
        if (FreeRegValid !== 3'b111) begin
            errors++;
            $display("FAIL reset_valid got %b exp 111", FreeRegValid);
        end
        checks++;
        if (fl_distance !== 5'd0 || empty_display !== 1'b0) begin
            errors++;
            $display("FAIL reset_dist_empty got %0d/%b exp 0/0", fl_distance, empty_display);
        end
        checks++;
        if (head_display !== 5'd0 || tail_display !== 5'd0 || Head !== '0) begin
            errors++;
            $display("FAIL reset_ptrs got h%0d t%0d H%0d exp 0 0 0", head_display, tail_display, Head);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (array_display[i] !== PR'(32 + i)) begin
                errors++;
                $display("FAIL reset_array%0d got %0d exp %0d", i, array_display[i], 32 + i);
            end
        end
    endtask

    task automatic test_dispatch_drain();
        apply_reset();
        cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        checks++;
        if (head_display !== 5'd3 || fl_distance !== 5'd3) begin
            errors++;
            $display("FAIL disp1_head_dist got %0d/%0d exp 3/3", head_display, fl_distance);
        end
        checks++;
        if (FreeReg[0] !== 6'd35 || FreeReg[1] !== 6'd36 || FreeReg[2] !== 6'd37) begin
            errors++;
            $display("FAIL disp1_freereg got %0d %0d %0d exp 35 36 37", FreeReg[0], FreeReg[1], FreeReg[2]);
        end
        for (int c = 0; c < 9; c++) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        checks++;
        if (head_display !== 5'd30 || FreeReg[0] !== 6'd62 || FreeReg[1] !== 6'd63 || FreeRegValid !== 3'b011) begin
            errors++;
            $display("FAIL disp10 got h%0d fr%0d fr%0d v%b exp h30 62 63 011",
                     head_display, FreeReg[0], FreeReg[1], FreeRegValid);
        end
        cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        checks++;
        if (head_display !== 5'd0 || empty_display !== 1'b1 || FreeRegValid !== 3'b000 || fl_distance !== 5'd0) begin
            errors++;
            $display("FAIL drain got h%0d e%b v%b d%0d exp h0 e1 v000 d0",
                     head_display, empty_display, FreeRegValid, fl_distance);
        end
    endtask

    task automatic test_retire_compaction();
        // Continues from the empty list left by test_dispatch_drain
        cycle(3'b000, 3'b001, 1, 0, 0, 1'b0, 0);
        checks++;
        if (array_display[0] !== 6'd1 || tail_display !== 5'd1 || FreeReg[0] !== 6'd1) begin
            errors++;
            $display("FAIL ret1 got a0=%0d t%0d fr0=%0d exp 1 1 1", array_display[0], tail_display, FreeReg[0]);
        end
        checks++;
        if (FreeRegValid !== 3'b001 || empty_display !== 1'b0) begin
            errors++;
            $display("FAIL ret1_valid got v%b e%b exp 001 0", FreeRegValid, empty_display);
        end
        cycle(3'b001, 3'b101, 5, 9, 7, 1'b0, 0);
        checks++;
        if (array_display[1] !== 6'd5 || array_display[2] !== 6'd7 || tail_display !== 5'd3) begin
            errors++;
            $display("FAIL ret101 got a1=%0d a2=%0d t%0d exp 5 7 3", array_display[1], array_display[2], tail_display);
        end
        checks++;
        if (head_display !== 5'd1 || FreeReg[0] !== 6'd5 || FreeReg[1] !== 6'd7 || FreeRegValid !== 3'b011) begin
            errors++;
            $display("FAIL ret101_disp got h%0d fr%0d fr%0d v%b exp h1 5 7 011",
                     head_display, FreeReg[0], FreeReg[1], FreeRegValid);
        end
    endtask

    task automatic test_recovery();
        apply_reset();
        cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        checks++;
        if (head_display !== 5'd6) begin
            errors++;
            $display("FAIL rec_pre got h%0d exp 6", head_display);
        end
        cycle(3'b111, 3'b000, 0, 0, 0, 1'b1, 3);
        checks++;
        if (head_display !== 5'd3 || Head !== 6'd3 || fl_distance !== 5'd3) begin
            errors++;
            $display("FAIL rec_head got h%0d H%0d d%0d exp 3 3 3", head_display, Head, fl_distance);
        end
        checks++;
        if (FreeReg[0] !== 6'd35 || FreeReg[1] !== 6'd36 || FreeReg[2] !== 6'd37 || FreeRegValid !== 3'b111) begin
            errors++;
            $display("FAIL rec_freereg got %0d %0d %0d v%b exp 35 36 37 111",
                     FreeReg[0], FreeReg[1], FreeReg[2], FreeRegValid);
        end
        // 29 free: nine full allocations leave exactly two
        for (int c = 0; c < 9; c++) cycle(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
        checks++;
        if (head_display !== 5'd30 || FreeRegValid !== 3'b011) begin
            errors++;
            $display("FAIL rec_count got h%0d v%b exp 30 011", head_display, FreeRegValid);
        end
    endtask

    task automatic test_random();
        logic [2:0] d;
        logic [2:0] r;
        logic       rec;
        int         k;
        int         rh;
        int         slack;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: d = 3'b000;
                1: d = 3'b001;
                2: d = 3'b011;
                default: d = 3'b111;
            endcase
            r = 3'($urandom_range(0, 7));
            k = int'(r[0]) + int'(r[1]) + int'(r[2]);
            while (m_free + k > 32) begin
                r[$urandom_range(0, 2)] = 1'b0;
                k = int'(r[0]) + int'(r[1]) + int'(r[2]);
            end
            rec   = ($urandom_range(0, 7) == 0);
            slack = 32 - m_free - k;
            rh    = mod32(m_head - int'($urandom_range(0, slack)));
            cycle(d, r, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)), rec, rh);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (FreeReg[i] !== PR'(m_mem[mod32(m_head + i)])) begin
                    errors++;
                    $display("FAIL rnd_freereg%0d cyc %0d got %0d exp %0d",
                             i, c, FreeReg[i], m_mem[mod32(m_head + i)]);
                end
            end
            checks++;
            if (FreeRegValid !== m_valid() || empty_display !== (m_free == 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d got v%b e%b exp v%b e%b",
                         c, FreeRegValid, empty_display, m_valid(), (m_free == 0));
            end
            checks++;
            if (head_display !== 5'(m_head) || tail_display !== 5'(m_tail) ||
                fl_distance !== 5'(mod32(m_head - m_tail))) begin
                errors++;
                $display("FAIL rnd_ptrs cyc %0d got h%0d t%0d d%0d exp h%0d t%0d d%0d", c,
                         head_display, tail_display, fl_distance, m_head, m_tail, mod32(m_head - m_tail));
            end
            if (c % 64 == 63) begin
                for (int i = 0; i < 32; i++) begin
                    checks++;
                    if (array_display[i] !== PR'(m_mem[i])) begin
                        errors++;
                        $display("FAIL rnd_array%0d cyc %0d got %0d exp %0d", i, c, array_display[i], m_mem[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        cycle(3'b011, 3'b000, 0, 0, 0, 1'b0, 0);
        cycle(3'b111, 3'b010, 0, 4, 0, 1'b0, 0);
        DispatchEN  = 3'b111;
        RetireEN    = 3'b111;
        RetireReg   = '0;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        checks++;
        if (head_display !== 5'd0 || tail_display !== 5'd0 || FreeRegValid !== 3'b111 || empty_display !== 1'b0) begin
            errors++;
            $display("FAIL midreset got h%0d t%0d v%b e%b exp 0 0 111 0",
                     head_display, tail_display, FreeRegValid, empty_display);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (array_display[i] !== PR'(32 + i)) begin
                errors++;
                $display("FAIL midreset_array%0d got %0d exp %0d", i, array_display[i], 32 + i);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_dispatch_drain();
        test_retire_compaction();
        test_recovery();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
